// File: rtl/sna_pkg.sv
// Shared types and constants for the SNA request receiver.
// SNA_RX_PARITY_EN widens each flit by one even-parity bit at the top.
package sna_pkg;

  localparam int unsigned FLIT_W    = 37;
  localparam int unsigned PAYLOAD_W = 32;
  localparam int unsigned VC_W      = 3;
  localparam int unsigned POV_W     = 4;

`ifdef SNA_RX_PARITY_EN
  localparam int unsigned FLIT_IN_W = FLIT_W + 1;
`else
  localparam int unsigned FLIT_IN_W = FLIT_W;
`endif

  localparam int unsigned TYPE_MSB = 36;
  localparam int unsigned TYPE_LSB = 35;
  localparam int unsigned VC_MSB   = 34;
  localparam int unsigned VC_LSB   = 32;

  localparam int unsigned HEAD_READ_BIT = 0;
  localparam int unsigned HEAD_POV_LSB  = 1;

  typedef enum logic [1:0] {
    FLIT_INV  = 2'b00,
    FLIT_HEAD = 2'b01,
    FLIT_BODY = 2'b10,
    FLIT_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_DATA,
    ST_PRESENT
  } rx_state_e;

endpackage

// File: rtl/sna_request_receiver_if.sv
// Router/transmitter-facing bundle of the SNA request receiver.
// Flit width follows SNA_RX_PARITY_EN through sna_pkg::FLIT_IN_W.
interface sna_request_receiver_if import sna_pkg::*; #(
  parameter int unsigned NUM_VC = 8
);
  logic [FLIT_IN_W-1:0] flit_in;
  logic                 flit_valid;
  logic [NUM_VC-1:0]    on_off;
  logic [PAYLOAD_W-1:0] addr;
  logic [PAYLOAD_W-1:0] data;
  logic                 read;
  logic [POV_W-1:0]     pov_addr;
  logic                 is_valid;
  logic                 req_ready;
  logic                 proto_err;

  modport slave (
    input  flit_in, flit_valid, req_ready,
    output on_off, addr, data, read, pov_addr, is_valid, proto_err
  );

  modport master (
    output flit_in, flit_valid, req_ready,
    input  on_off, addr, data, read, pov_addr, is_valid, proto_err
  );
endinterface

// File: rtl/sna_flit_fifo.sv
// Show-ahead flit FIFO: o_head shows the oldest entry whenever not empty.
// A push at full is accepted only when a pop frees the slot in the same cycle.
module sna_flit_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_wr) - CW'(w_rd);
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/sna_request_receiver.sv
// SNA request receiver: buffers router flits and reassembles them into one request.
// Optional SNA_RX_PARITY_EN checks even parity on every popped flit.
module sna_request_receiver import sna_pkg::*; #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned OFF_MARGIN = 2,
  parameter int unsigned NUM_VC     = 8
) (
  input logic                   clock,
  input logic                   reset,
  sna_request_receiver_if.slave bus
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [FLIT_IN_W-1:0] w_head;
  logic [CW-1:0]        w_count;
  logic [CW-1:0]        w_cnt_nxt;
  logic                 w_full, w_empty, w_pop, w_push_ok, w_drop;
  flit_type_e           w_type;
  logic [PAYLOAD_W-1:0] w_pl;
  logic                 w_par_bad;
  logic                 w_unused_vc;

  rx_state_e            r_state, w_state_nxt;
  logic                 w_ld_hdr, w_ld_addr, w_ld_data, w_clr_data, w_pkt_err;
  logic                 w_disc_set, w_disc_clr;

  logic [PAYLOAD_W-1:0] r_addr, r_data;
  logic                 r_read, r_proto_err, r_discard;
  logic [POV_W-1:0]     r_pov;
  logic [NUM_VC-1:0]    r_on_off;

  assign w_pop     = !w_empty && (r_state != ST_PRESENT);
  assign w_push_ok = bus.flit_valid && (!w_full || w_pop);
  assign w_drop    = bus.flit_valid && w_full && !w_pop;
  assign w_cnt_nxt = w_count + CW'(w_push_ok) - CW'(w_pop);

  sna_flit_fifo #(.WIDTH(FLIT_IN_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (bus.flit_valid),
    .i_pop   (w_pop),
    .i_data  (bus.flit_in),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_type      = flit_type_e'(w_head[TYPE_MSB:TYPE_LSB]);
  assign w_pl        = w_head[PAYLOAD_W-1:0];
  assign w_unused_vc = ^w_head[VC_MSB:VC_LSB];

`ifdef SNA_RX_PARITY_EN
  assign w_par_bad = ^w_head;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ld_hdr    = 1'b0;
    w_ld_addr   = 1'b0;
    w_ld_data   = 1'b0;
    w_clr_data  = 1'b0;
    w_pkt_err   = 1'b0;
    w_disc_set  = 1'b0;
    w_disc_clr  = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_pop) begin
        if (w_type == FLIT_HEAD) begin
          w_ld_hdr    = 1'b1;
          w_disc_clr  = 1'b1;
          w_state_nxt = ST_GET_ADDR;
        end else begin
          w_pkt_err = !r_discard;
        end
      end
      ST_GET_ADDR: if (w_pop) begin
        if (w_type == FLIT_HEAD) begin
          w_ld_hdr  = 1'b1;
          w_pkt_err = 1'b1;
        end else if (w_type == FLIT_TAIL && r_read) begin
          w_ld_addr   = 1'b1;
          w_clr_data  = 1'b1;
          w_state_nxt = ST_PRESENT;
        end else if (w_type == FLIT_BODY && !r_read) begin
          w_ld_addr   = 1'b1;
          w_state_nxt = ST_GET_DATA;
        end else begin
          w_pkt_err   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GET_DATA: if (w_pop) begin
        if (w_type == FLIT_HEAD) begin
          w_ld_hdr    = 1'b1;
          w_pkt_err   = 1'b1;
          w_state_nxt = ST_GET_ADDR;
        end else if (w_type == FLIT_TAIL) begin
          w_ld_data   = 1'b1;
          w_state_nxt = ST_PRESENT;
        end else begin
          w_pkt_err   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRESENT: if (bus.req_ready) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
    // A corrupt flit overrides everything: drop back and swallow flits until a clean head.
    if (w_pop && w_par_bad) begin
      w_ld_hdr    = 1'b0;
      w_ld_addr   = 1'b0;
      w_ld_data   = 1'b0;
      w_clr_data  = 1'b0;
      w_pkt_err   = 1'b1;
      w_disc_set  = 1'b1;
      w_disc_clr  = 1'b0;
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr      <= '0;
      r_data      <= '0;
      r_read      <= 1'b0;
      r_pov       <= '0;
      r_proto_err <= 1'b0;
      r_on_off    <= '0;
      r_discard   <= 1'b0;
    end else begin
      if (w_ld_hdr) begin
        r_read <= w_pl[HEAD_READ_BIT];
        r_pov  <= w_pl[HEAD_POV_LSB +: POV_W];
      end
      if (w_ld_addr)  r_addr <= w_pl;
      if (w_clr_data) r_data <= '0;
      if (w_ld_data)  r_data <= w_pl;
      if (w_disc_set)      r_discard <= 1'b1;
      else if (w_disc_clr) r_discard <= 1'b0;
      r_proto_err <= w_drop | w_pkt_err;
      r_on_off    <= (w_cnt_nxt >= CW'(FIFO_DEPTH - OFF_MARGIN)) ? '1 : '0;
    end
  end

  assign bus.on_off    = r_on_off;
  assign bus.addr      = r_addr;
  assign bus.data      = r_data;
  assign bus.read      = r_read;
  assign bus.pov_addr  = r_pov;
  assign bus.is_valid  = (r_state == ST_PRESENT);
  assign bus.proto_err = r_proto_err;
endmodule

// File: tb/tb_sna_request_receiver.sv
// Self-checking bench for sna_request_receiver: expected-request scoreboard plus directed timing checks.
module tb_sna_request_receiver;
  import sna_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sna_request_receiver_if #(.NUM_VC(8)) bus ();

  sna_request_receiver #(.FIFO_DEPTH(8), .OFF_MARGIN(2), .NUM_VC(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        read;
    logic [3:0]  pov;
  } req_t;

  req_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   pulses    = 0;
  int   delivered = 0;
  logic prev_acc  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [FLIT_IN_W-1:0] mk(input logic [1:0] t, input logic [31:0] pl);
    logic [36:0] f;
    f = {t, 3'd5, pl};
`ifdef SNA_RX_PARITY_EN
    return {^f, f};
`else
    return f;
`endif
  endfunction

  function automatic logic [31:0] hpl(input logic rd, input logic [3:0] pov);
    return {27'd0, pov, rd};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [1:0] t, input logic [31:0] pl);
    bus.flit_valid = 1'b1;
    bus.flit_in    = mk(t, pl);
    tick();
    bus.flit_valid = 1'b0;
  endtask

  task automatic expect_req(input logic rd, input logic [3:0] pov, input logic [31:0] a, input logic [31:0] d);
    req_t r;
    r.addr = a;
    r.data = rd ? 32'd0 : d;
    r.read = rd;
    r.pov  = pov;
    sb.push_back(r);
  endtask

  task automatic send_write(input logic [3:0] pov, input logic [31:0] a, input logic [31:0] d);
    expect_req(1'b0, pov, a, d);
    send(FLIT_HEAD, hpl(1'b0, pov));
    send(FLIT_BODY, a);
    send(FLIT_TAIL, d);
  endtask

  task automatic send_read(input logic [3:0] pov, input logic [31:0] a);
    expect_req(1'b1, pov, a, 32'd0);
    send(FLIT_HEAD, hpl(1'b1, pov));
    send(FLIT_TAIL, a);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!bus.is_valid && n < 20) begin
      tick();
      n++;
    end
    chk(name, bus.is_valid, 1);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  // Scoreboard: every presented request must match the oldest expected one until accepted.
  always @(negedge clock) begin
    if (!reset) begin
      if (bus.proto_err) pulses++;
      if (prev_acc) chk("clear_after_accept", bus.is_valid, 0);
      prev_acc = 1'b0;
      if (bus.is_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", bus.is_valid, 0);
        end else begin
          chk("sb_addr", bus.addr, sb[0].addr);
          chk("sb_data", bus.data, sb[0].data);
          chk("sb_read", bus.read, sb[0].read);
          chk("sb_pov",  bus.pov_addr, sb[0].pov);
          if (bus.req_ready) begin
            void'(sb.pop_front());
            delivered++;
            prev_acc = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int p;
    bus.flit_valid = 1'b0;
    bus.flit_in    = '0;
    bus.req_ready  = 1'b0;
    reset          = 1'b1;
    repeat (3) tick();
    chk("rst_on_off",   bus.on_off,    8'h00);
    chk("rst_is_valid", bus.is_valid,  0);
    chk("rst_addr",     bus.addr,      0);
    chk("rst_data",     bus.data,      0);
    chk("rst_read",     bus.read,      0);
    chk("rst_pov",      bus.pov_addr,  0);
    chk("rst_perr",     bus.proto_err, 0);
    reset = 1'b0;
    tick();

    // Write request, ready high: valid exactly at tail+2 for one cycle.
    bus.req_ready = 1'b1;
    send_write(4'b0101, 32'h55555555, 32'hFFFFFFFF);
    @(negedge clock);
    chk("wr_t1_valid", bus.is_valid, 0);
    @(negedge clock);
    chk("wr_t2_valid", bus.is_valid, 1);
    chk("wr_addr", bus.addr, 32'h55555555);
    chk("wr_data", bus.data, 32'hFFFFFFFF);
    chk("wr_read", bus.read, 0);
    chk("wr_pov",  bus.pov_addr, 4'd5);
    @(negedge clock);
    chk("wr_one_cycle", bus.is_valid, 0);
    tick();

    // Read request held for 5 cycles with ready low.
    bus.req_ready = 1'b0;
    tick();
    send_read(4'd3, 32'h1000);
    @(negedge clock);
    chk("rd_t1_valid", bus.is_valid, 0);
    @(negedge clock);
    chk("rd_t2_valid", bus.is_valid, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("rd_hold_valid", bus.is_valid, 1);
      chk("rd_hold_data",  bus.data, 0);
      chk("rd_hold_addr",  bus.addr, 32'h1000);
      chk("rd_hold_read",  bus.read, 1);
    end
    tick();
    bus.req_ready = 1'b1;
    @(negedge clock);
    chk("rd_still_valid", bus.is_valid, 1);
    @(negedge clock);
    chk("rd_cleared", bus.is_valid, 0);
    tick();

    // Back-pressure: 6 flits buffered behind a presented request.
    bus.req_ready = 1'b0;
    tick();
    p = pulses;
    send_read(4'd1, 32'h2000);
    wait_valid("bp_present");
    send_write(4'd7, 32'h100, 32'h101);
    expect_req(1'b0, 4'd8, 32'h200, 32'h201);
    send(FLIT_HEAD, hpl(1'b0, 4'd8));
    send(FLIT_BODY, 32'h200);
    chk("bp_5_off", bus.on_off, 8'h00);
    send(FLIT_TAIL, 32'h201);
    chk("bp_6_on", bus.on_off, 8'hFF);
    tick();
    bus.req_ready = 1'b1;
    drain("bp_drain");
    tick();
    chk("bp_off", bus.on_off, 8'h00);
    chk("bp_no_err", pulses - p, 0);

    // Overflow: fill 8 entries, a 9th flit is dropped.
    bus.req_ready = 1'b0;
    tick();
    p = pulses;
    send_read(4'd2, 32'h3000);
    wait_valid("ovf_present");
    send_write(4'd8, 32'h300, 32'h301);
    send_write(4'd9, 32'h400, 32'h401);
    send_read(4'd10, 32'h500);
    chk("ovf_full_on", bus.on_off, 8'hFF);
    send(FLIT_HEAD, hpl(1'b1, 4'd15));
    chk("ovf_err_pulse", bus.proto_err, 1);
    tick();
    chk("ovf_err_one", bus.proto_err, 0);
    bus.req_ready = 1'b1;
    drain("ovf_drain");
    repeat (8) tick();
    chk("ovf_pulses", pulses - p, 1);

    // Protocol errors: stray body, then a head restarting a partial write.
    p = pulses;
    send(FLIT_BODY, 32'hDEAD);
    send(FLIT_HEAD, hpl(1'b0, 4'd2));
    send(FLIT_BODY, 32'hA0);
    expect_req(1'b1, 4'd9, 32'hB0, 32'd0);
    send(FLIT_HEAD, hpl(1'b1, 4'd9));
    send(FLIT_TAIL, 32'hB0);
    drain("perr_drain");
    repeat (3) tick();
    chk("perr_pulses", pulses - p, 2);

    // Reset mid-packet clears everything; next packet is normal.
    send(FLIT_HEAD, hpl(1'b0, 4'd6));
    send(FLIT_BODY, 32'h77);
    reset = 1'b1;
    tick();
    chk("rst2_is_valid", bus.is_valid, 0);
    chk("rst2_addr",     bus.addr, 0);
    chk("rst2_data",     bus.data, 0);
    chk("rst2_read",     bus.read, 0);
    chk("rst2_pov",      bus.pov_addr, 0);
    chk("rst2_on_off",   bus.on_off, 8'h00);
    chk("rst2_perr",     bus.proto_err, 0);
    reset = 1'b0;
    tick();
    p = pulses;
    send_write(4'd6, 32'h1234, 32'h5678);
    drain("rst_drain");
    repeat (5) tick();
    chk("rst_no_err", pulses - p, 0);
    chk("sb_empty_end", sb.size(), 0);
    chk("delivered", delivered, 11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
